mic_array_scheduler: RTL and testbench

- Sequences a bank of PAIR_NUM mic-pair cross-correlation subsystems, one pair at a time: pulse start, wait for done, capture the signed lag.
- Assembles the per-pair lags into one frame for the downstream localisation/display logic and flags pairs that fail to answer within a cycle budget.
- Sits in the 60 MHz audio-processing domain between the top-level control and the mic_subsys instances.

---
 rtl/mic_array_scheduler.sv | 142 ++++++++++++++
 tb/tb_mic_array_scheduler.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_array_scheduler.sv
// Sequences PAIR_NUM mic-pair correlators one at a time, collects their signed lags
// into a shadow frame and publishes it atomically with a per-pair timeout mask.
module mic_array_scheduler #(
    parameter int PAIR_NUM    = 4,
    parameter int LAG_W       = 6,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                      clk_60MHz,
    input  logic                      rst_n,
    input  logic                      scan_req,
    input  logic                      scan_en,
    input  logic                      abort,
    output logic [PAIR_NUM-1:0]       sub_start,
    input  logic [PAIR_NUM-1:0]       sub_done,
    input  logic [PAIR_NUM*LAG_W-1:0] sub_lag,
    output logic [PAIR_NUM*LAG_W-1:0] lag_out,
    output logic [PAIR_NUM-1:0]       timeout_mask,
    output logic                      frame_valid,
    output logic                      busy,
    output logic [15:0]               frame_cnt
);

    localparam int IDX_W = $clog2(PAIR_NUM);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAIR_NUM - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        NEXT,
        PUBLISH
    } state_t;

    state_t                    state, state_nxt;
    logic [IDX_W-1:0]          idx, idx_nxt;
    logic [TMR_W-1:0]          timer, timer_nxt;
    logic                      cap_lag, cap_tmo, clr_mask;
    logic [PAIR_NUM*LAG_W-1:0] shadow_lag;
    logic [PAIR_NUM-1:0]       shadow_mask;

    always_ff @(posedge clk_60MHz) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        timer_nxt = timer;
        cap_lag   = 1'b0;
        cap_tmo   = 1'b0;
        clr_mask  = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (scan_req || scan_en) begin
                        state_nxt = START;
                        idx_nxt   = '0;
                        clr_mask  = 1'b1;
                    end
                end
                START: begin
                    timer_nxt = '0;
                    state_nxt = WAIT;
                end
                WAIT: begin
                    // done is checked first so a reply on the last budget cycle still counts
                    if (sub_done[idx]) begin
                        cap_lag   = 1'b1;
                        state_nxt = NEXT;
                    end else if (timer == TMR_LAST) begin
                        cap_tmo   = 1'b1;
                        state_nxt = NEXT;
                    end else begin
                        timer_nxt = timer + TMR_W'(1);
                    end
                end
                NEXT: begin
                    if (idx == IDX_LAST) begin
                        state_nxt = PUBLISH;
                    end else begin
                        idx_nxt   = idx + IDX_W'(1);
                        state_nxt = START;
                    end
                end
                PUBLISH: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state
    // they describe instead of lagging it by a cycle.
    // NOTE: sequential state uses non-blocking assignments only; blocking here would
    // let later statements see this edge's new values and create ordering races.
    always_ff @(posedge clk_60MHz) begin
        if (!rst_n) begin
            idx          <= '0;
            timer        <= '0;
            shadow_lag   <= '0;
            shadow_mask  <= '0;
            sub_start    <= '0;
            lag_out      <= '0;
            timeout_mask <= '0;
            frame_valid  <= 1'b0;
            busy         <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            idx   <= idx_nxt;
            timer <= timer_nxt;
            if (clr_mask) begin
                shadow_mask <= '0;
            end
            if (cap_lag) begin
                shadow_lag[idx*LAG_W +: LAG_W] <= sub_lag[idx*LAG_W +: LAG_W];
            end
            if (cap_tmo) begin
                shadow_lag[idx*LAG_W +: LAG_W] <= '0;
                shadow_mask[idx]               <= 1'b1;
            end
            sub_start   <= (state_nxt == START) ? (PAIR_NUM'(1) << idx_nxt) : '0;
            busy        <= (state_nxt != IDLE);
            frame_valid <= (state_nxt == PUBLISH);
            if (state_nxt == PUBLISH) begin
                lag_out      <= shadow_lag;
                timeout_mask <= shadow_mask;
                frame_cnt    <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mic_array_scheduler.sv
// Randomised bench for mic_array_scheduler: a per-frame timeline model predicts start
// pulses, publish cycle and the published frame from the pair reply delays.
module tb_mic_array_scheduler;

    localparam int P  = 4;
    localparam int LW = 6;
    localparam int TO = 64;

    logic              clk_60MHz = 1'b0;
    logic              rst_n     = 1'b0;
    logic              scan_req  = 1'b0;
    logic              scan_en   = 1'b0;
    logic              abort     = 1'b0;
    logic [P-1:0]      sub_start;
    logic [P-1:0]      sub_done  = '0;
    logic [P*LW-1:0]   sub_lag   = '0;
    logic [P*LW-1:0]   lag_out;
    logic [P-1:0]      timeout_mask;
    logic              frame_valid;
    logic              busy;
    logic [15:0]       frame_cnt;

    mic_array_scheduler #(.PAIR_NUM(P), .LAG_W(LW), .TIMEOUT_CYC(TO)) dut (
        .clk_60MHz    (clk_60MHz),
        .rst_n        (rst_n),
        .scan_req     (scan_req),
        .scan_en      (scan_en),
        .abort        (abort),
        .sub_start    (sub_start),
        .sub_done     (sub_done),
        .sub_lag      (sub_lag),
        .lag_out      (lag_out),
        .timeout_mask (timeout_mask),
        .frame_valid  (frame_valid),
        .busy         (busy),
        .frame_cnt    (frame_cnt)
    );

    always #8 clk_60MHz = ~clk_60MHz;

    int n_checks = 0;
    int n_errors = 0;

    // reply delay per pair in cycles after its start; anything above TO never answers
    int              dly[P];
    logic [LW-1:0]   lag_val[P];
    logic [P*LW-1:0] exp_lag  = '0;
    logic [P-1:0]    exp_mask = '0;
    logic [15:0]     exp_cnt  = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] obs_frame();
        return 64'({frame_cnt, timeout_mask, lag_out});
    endfunction

    function automatic logic [63:0] exp_frame();
        return 64'({exp_cnt, exp_mask, exp_lag});
    endfunction

    function automatic logic [63:0] obs_ctl();
        return 64'({busy, frame_valid, sub_start});
    endfunction

    function automatic int rand_dly();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return TO;
        if (r == 1) return TO + 1 + int'($urandom_range(0, 5));
        return int'($urandom_range(1, 20));
    endfunction

    // One frame, entered just before its IDLE request cycle (period 0).
    // kill_pair >= 0 aborts (or resets) at period start(kill_pair)+kill_off.
    task automatic run_frame(input bit use_en, input int kill_pair, input int kill_off,
                             input bit kill_rst);
        int              s[P+1];
        int              w;
        int              pub;
        int              act;
        int              kill_at;
        logic [P*LW-1:0] new_lag;
        logic [P-1:0]    new_mask;
        logic [P-1:0]    exp_start;
        logic [P-1:0]    done_v;
        logic [P*LW-1:0] lag_v;

        s[0] = 1;
        for (int i = 0; i < P; i++) begin
            w        = (dly[i] < TO) ? dly[i] : TO;
            s[i+1]   = s[i] + 1 + w + 1;
            new_lag[i*LW +: LW] = (dly[i] <= TO) ? lag_val[i] : '0;
            new_mask[i]         = (dly[i] > TO);
        end
        pub     = s[P];
        kill_at = (kill_pair >= 0) ? s[kill_pair] + kill_off : -1;

        @(negedge clk_60MHz);
        check("idle_ctl", obs_ctl(), 64'd0);
        check("idle_frame", obs_frame(), exp_frame());
        scan_req = !use_en;
        scan_en  = use_en;
        abort    = 1'b0;
        sub_done = '0;

        for (int p = 1; p <= pub; p++) begin
            @(negedge clk_60MHz);
            exp_start = '0;
            act       = P - 1;
            for (int i = 0; i < P; i++) begin
                if (p == s[i]) exp_start[i] = 1'b1;
                if (p >= s[i] && p < s[i+1]) act = i;
            end
            if (p == pub) begin
                exp_lag  = new_lag;
                exp_mask = new_mask;
                exp_cnt  = exp_cnt + 16'd1;
            end
            check("ctl", obs_ctl(), 64'({1'b1, (p == pub), exp_start}));
            check("frame", obs_frame(), exp_frame());

            scan_req = ($urandom_range(0, 15) == 0);
            lag_v    = (P*LW)'($urandom);
            done_v   = '0;
            for (int i = 0; i < P; i++) begin
                if (i != act && $urandom_range(0, 7) == 0) done_v[i] = 1'b1;
            end
            if (dly[act] <= TO && p == s[act] + dly[act]) begin
                done_v[act]            = 1'b1;
                lag_v[act*LW +: LW]    = lag_val[act];
            end
            sub_done = done_v;
            sub_lag  = lag_v;

            if (p == kill_at) begin
                if (kill_rst) rst_n = 1'b0;
                else          abort = 1'b1;
                @(negedge clk_60MHz);
                if (kill_rst) begin
                    exp_lag  = '0;
                    exp_mask = '0;
                    exp_cnt  = '0;
                end
                check("kill_ctl", obs_ctl(), 64'd0);
                check("kill_frame", obs_frame(), exp_frame());
                rst_n    = 1'b1;
                abort    = 1'b0;
                scan_req = 1'b0;
                sub_done = '0;
                return;
            end
        end
    endtask

    task automatic set_lags_random();
        for (int i = 0; i < P; i++) begin
            dly[i]     = rand_dly();
            lag_val[i] = LW'($urandom);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk_60MHz);
        @(negedge clk_60MHz);
        check("rst_ctl", obs_ctl(), 64'd0);
        check("rst_frame", obs_frame(), 64'd0);
        rst_n = 1'b1;

        // Normal frame with lags -16, 0, 5, 15, each answering 10 cycles after start.
        lag_val[0] = 6'h30; lag_val[1] = 6'd0; lag_val[2] = 6'd5; lag_val[3] = 6'd15;
        for (int i = 0; i < P; i++) dly[i] = 10;
        run_frame(1'b0, -1, 0, 1'b0);
        check("tp_lag", 64'(lag_out), 64'({6'd15, 6'd5, 6'd0, 6'h30}));
        check("tp_mask", 64'(timeout_mask), 64'd0);
        check("tp_cnt", 64'(frame_cnt), 64'd1);

        // Pair 2 silent: times out after TO wait cycles.
        set_lags_random();
        dly[0] = 10; dly[1] = 7; dly[2] = TO + 100; dly[3] = 3;
        run_frame(1'b0, -1, 0, 1'b0);
        check("tmo_mask", 64'(timeout_mask), 64'b0100);
        check("tmo_slice", 64'(lag_out[2*LW +: LW]), 64'd0);

        // Done on the final budget cycle of pair 1 beats the timeout.
        set_lags_random();
        dly[1] = TO; dly[2] = 5;
        lag_val[1] = 6'h2A;
        run_frame(1'b0, -1, 0, 1'b0);
        check("tie_mask1", 64'(timeout_mask[1]), 64'd0);
        check("tie_lag1", 64'(lag_out[LW +: LW]), 64'h2A);

        // Abort during pair 2 WAIT: frame dropped, outputs held.
        set_lags_random();
        dly[2] = 15;
        run_frame(1'b0, 2, 2, 1'b0);

        // Abort in IDLE blocks the request in the same cycle.
        @(negedge clk_60MHz);
        check("iab_pre", obs_ctl(), 64'd0);
        scan_req = 1'b1;
        abort    = 1'b1;
        @(negedge clk_60MHz);
        check("iab_ctl", obs_ctl(), 64'd0);
        scan_req = 1'b0;
        abort    = 1'b0;

        for (int f = 0; f < 5; f++) begin
            set_lags_random();
            run_frame(1'b0, -1, 0, 1'b0);
        end

        // Continuous mode: three back-to-back frames, then scan_en drops.
        for (int f = 0; f < 3; f++) begin
            set_lags_random();
            run_frame(1'b1, -1, 0, 1'b0);
        end
        @(negedge clk_60MHz);
        check("cont_idle", obs_ctl(), 64'd0);
        scan_en  = 1'b0;
        scan_req = 1'b0;
        sub_done = '0;
        @(negedge clk_60MHz);
        check("cont_stop", obs_ctl(), 64'd0);
        check("cont_frame", obs_frame(), exp_frame());

        // Reset mid-frame, then a clean frame from pair 0.
        set_lags_random();
        dly[1] = 12;
        run_frame(1'b0, 1, 3, 1'b1);
        set_lags_random();
        run_frame(1'b0, -1, 0, 1'b0);
        check("post_rst_cnt", 64'(frame_cnt), 64'd1);

        @(negedge clk_60MHz);
        check("end_idle", obs_ctl(), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
